lcd_msg_scheduler: RTL
======================

Name: lcd_msg_scheduler

Overview:
- Owns the 8-bit HD44780-style LCD bus: rs, rw, enable, data.
- After reset, runs the power-up wait and the 4-command init sequence, then shares the bus between NUM_REQ message requesters with round-robin arbitration.
- Each granted message is one DDRAM address command followed by MSG_LEN characters, each with parameterised setup/enable/hold timing.
- Sits between the text/colour producers and the LCD pins, replacing the free-running clk_16ms strobe.

Parameters:
- NUM_REQ, 2, number of requesters.
- MSG_LEN, 8, characters per message.
- SETUP_CYC, 4, clk cycles with data/rs stable before enable rises.
- EN_CYC, 24, clk cycles enable is high.
- HOLD_CYC, 2400, clk cycles enable is low after the pulse, before the next byte.
- CLEAR_CYC, 100000, hold replacing HOLD_CYC after command 0x01.
- POWERUP_CYC, 1000000, wait after reset before the first init command.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester message request (level)
- addr_i  in  7*NUM_REQ  per-requester DDRAM start address; slice r = bits [7r+6:7r]
- char_i  in  8*NUM_REQ  per-requester character for the current char_idx
- char_idx  out  clog2(MSG_LEN)  index of the character being fetched
- grant  out  NUM_REQ  one-hot; high for the whole message of the granted requester
- done  out  NUM_REQ  one-cycle pulse to the granted requester at message end
- init_done  out  1  high once the init sequence has completed
- busy  out  1  high in every state except IDLE
- rs  out  1  0 = command, 1 = data
- rw  out  1  tied 0 (write only)
- enable  out  1  LCD E strobe
- data  out  8  LCD data bus

Behaviour:
- Reset (async, any state): state=PWRUP; all counters 0; rs=0, rw=0, enable=0, data=0x00, grant=0, done=0, char_idx=0, init_done=0, busy=1; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Byte phase, shared by all bus writes:
  - data/rs are registered at phase entry and held constant for the whole phase.
  - enable=0 for SETUP_CYC cycles, then 1 for EN_CYC cycles, then 0 for HOLD_CYC cycles (CLEAR_CYC if data==0x01 and rs==0).
  - Phase length = SETUP_CYC+EN_CYC+hold cycles exactly; the next phase starts on the following cycle.
- PWRUP: counts POWERUP_CYC cycles, then moves to INIT.
- INIT: four byte phases with rs=0, in order 0x38, 0x06, 0x0C, 0x01. After the last phase ends: init_done=1 (sticky until reset), go to IDLE. Requests are ignored before init_done.
- IDLE: busy=0. If any req bit is high at an edge, then at the next edge:
  - the winner is the first set bit scanning from pointer+1 modulo NUM_REQ;
  - grant is set one-hot, pointer is updated to the winner, addr_i of the winner is captured;
  - state=ADDR with rs=0, data = 0x80 | addr.
- ADDR: one byte phase, then LOAD.
- LOAD: 1 cycle. char_idx=k is already valid; data <= char_i slice of the winner, rs <= 1; go to CHAR.
- CHAR: one byte phase. At its end:
  - if k==MSG_LEN-1: done pulse on the winner's bit, grant cleared and char_idx=0 in the same cycle, go to IDLE;
  - else: char_idx=k+1, go to LOAD.
- char_idx changes only at the end of a CHAR phase. Requesters have one full LOAD cycle to settle char_i combinationally.
- Requester rules:
  - req must stay high until its done pulse.
  - req dropping mid-message does not abort the message; it completes and done still pulses.
  - req still high after done is treated as a new request in IDLE, subject to round-robin.
  - Simultaneous requests are resolved only in IDLE; the loser waits.
- Address wrap: addr_i bit 7 is forced to 1 in the command; data is never 7 bits wide on the bus.
- rw is constant 0 in all states.

Test Plan:
- Use small params: NUM_REQ=2, MSG_LEN=4, SETUP=2, EN=3, HOLD=5, CLEAR=20, POWERUP=10.
- Reset/init: release reset with req=0 -> enable stays 0 for 10 cycles; bytes 38, 06, 0C, 01 appear with rs=0 and enable high for 3 cycles in each; the 0x01 hold lasts 20 cycles; init_done rises after that, busy falls.
- Single message: req0=1, addr=0x40, chars "ROJO" -> grant=01; bus shows C0 (rs=0), then 52, 4F, 4A, 4F (rs=1); char_idx 0..3; done[0] pulses once; 11 cycles per char byte (10 phase + 1 LOAD).
- Contention and round-robin: req=11 held -> messages complete in order 0, 1, 0, 1; grant never shows two bits; no gap longer than 1 IDLE arbitration cycle between messages.
- Early req drop: req0 dropped after the second char -> all 4 chars are still sent and done[0] pulses.
- Reset mid-message: assert reset during enable-high of char 2 -> enable=0, data=00, and grant=0 immediately (async); after release, the full init sequence repeats before any grant.
- Pre-init request: req1=1 during PWRUP -> no grant until init_done; then grant=10 on the cycle after IDLE is entered.

Source files
------------

// File: rtl/lcd_msg_scheduler.sv
// HD44780 8-bit bus owner: power-up wait, 4-command init, then round-robin
// scheduling of fixed-length messages (address command + MSG_LEN characters).
module lcd_msg_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int MSG_LEN     = 8,
  parameter int SETUP_CYC   = 4,
  parameter int EN_CYC      = 24,
  parameter int HOLD_CYC    = 2400,
  parameter int CLEAR_CYC   = 100000,
  parameter int POWERUP_CYC = 1000000,
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] addr_i,
  input  logic [8*NUM_REQ-1:0] char_i,
  output logic [IW-1:0]        char_idx,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 init_done,
  output logic                 busy,
  output logic                 rs,
  output logic                 rw,
  output logic                 enable,
  output logic [7:0]           data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] SETUP_L = 32'(SETUP_CYC);
  localparam logic [31:0] EN_L    = 32'(EN_CYC);
  localparam logic [31:0] HOLD_L  = 32'(HOLD_CYC);
  localparam logic [31:0] CLEAR_L = 32'(CLEAR_CYC);
  localparam logic [31:0] PWR_L   = 32'(POWERUP_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_LOAD, S_CHAR} state_t;

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [1:0]         init_idx_q, init_idx_d;
  logic [PW-1:0]      ptr_q, ptr_d, win_q, win_d;
  logic [IW-1:0]      char_idx_q, char_idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               init_done_q, init_done_d, busy_q, busy_d;
  logic               rs_q, rs_d, enable_q, enable_d;
  logic [7:0]         data_q, data_d;

  logic [31:0]        hold_s, phase_last_s;
  logic               phase_end_s, arb_found_s;
  logic [PW-1:0]      arb_win_s;
  logic [6:0]         addr_sel_s;
  logic [7:0]         char_sel_s;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      2'd3:    return 8'h01;
      default: return 8'h38;
    endcase
  endfunction

  // Byte-phase length; clear-display needs the long hold.
  always_comb begin
    hold_s       = ((data_q == 8'h01) && !rs_q) ? CLEAR_L : HOLD_L;
    phase_last_s = SETUP_L + EN_L + hold_s - 32'd1;
    phase_end_s  = (cnt_q == phase_last_s);
  end

  // Round-robin: first set req bit after the last winner.
  always_comb begin
    logic [PW-1:0] cand_v;
    logic          take_v;
    cand_v      = '0;
    take_v      = 1'b0;
    arb_found_s = 1'b0;
    arb_win_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_v      = PW'((int'(ptr_q) + i) % NUM_REQ);
      take_v      = !arb_found_s && req[cand_v];
      arb_win_s   = take_v ? cand_v : arb_win_s;
      arb_found_s = arb_found_s | take_v;
    end
  end

  // Requester slice muxes: address by fresh winner, character by held winner.
  always_comb begin
    addr_sel_s = '0;
    char_sel_s = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_sel_s = addr_sel_s | ({7{arb_win_s == PW'(r)}} & addr_i[7*r +: 7]);
      char_sel_s = char_sel_s | ({8{win_q == PW'(r)}} & char_i[8*r +: 8]);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    init_idx_d  = init_idx_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    char_idx_d  = char_idx_q;
    grant_d     = grant_q;
    done_d      = '0;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWR_L - 32'd1) begin
          state_d    = S_INIT;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
        end else begin
          state_d = S_PWRUP;
        end
      end
      S_INIT: begin
        if (phase_end_s) begin
          cnt_d = '0;
          if (init_idx_q == 2'd3) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            data_d     = init_cmd(init_idx_q + 2'd1);
          end
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (arb_found_s) begin
          state_d            = S_ADDR;
          grant_d            = '0;
          grant_d[arb_win_s] = 1'b1;
          ptr_d              = arb_win_s;
          win_d              = arb_win_s;
          rs_d               = 1'b0;
          data_d             = {1'b1, addr_sel_s};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (phase_end_s) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_LOAD: begin
        state_d = S_CHAR;
        cnt_d   = '0;
        rs_d    = 1'b1;
        data_d  = char_sel_s;
      end
      S_CHAR: begin
        if (phase_end_s) begin
          cnt_d = '0;
          if (char_idx_q == LAST_IDX) begin
            state_d    = S_IDLE;
            done_d     = grant_q;
            grant_d    = '0;
            char_idx_d = '0;
          end else begin
            state_d    = S_LOAD;
            char_idx_d = char_idx_q + IW'(1);
          end
        end else begin
          state_d = S_CHAR;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
    busy_d   = (state_d != S_IDLE);
    enable_d = ((state_d == S_INIT) || (state_d == S_ADDR) || (state_d == S_CHAR)) &&
               (cnt_d >= SETUP_L) && (cnt_d < SETUP_L + EN_L);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      init_idx_q  <= 2'd0;
      ptr_q       <= PW'(NUM_REQ - 1);
      win_q       <= '0;
      char_idx_q  <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      rs_q        <= 1'b0;
      enable_q    <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      char_idx_q  <= char_idx_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      rs_q        <= rs_d;
      enable_q    <= enable_d;
      data_q      <= data_d;
    end
  end

  assign char_idx  = char_idx_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign rs        = rs_q;
  assign rw        = 1'b0;
  assign enable    = enable_q;
  assign data      = data_q;

endmodule
